ram_2p_param: RTL and testbench
===============================

Name: ram_2p_param

Overview:
- Parametrised true dual-port synchronous RAM; next-generation CPU data/instruction store.
- Generalises the fixed 16x128 two-port RAM in width and depth.
- Adds a post-reset clear sequencer, read-valid strobes, an optional output pipeline stage, cross-port write-first bypass, and collision/error reporting.
- Sits between the CPU load/store unit (port 0) and the fetch/DMA path (port 1).

Parameters:
- DATA_W, 16: data word width in bits.
- ADDR_W, 7: address width. Depth is 2**ADDR_W words.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- CLEAR_ON_RESET, 1: 1 zeroes all words after reset; 0 leaves memory uncleared and makes the block ready immediately.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- read_en0  in  1  port 0 read request.
- write_en0  in  1  port 0 write request.
- addr0  in  ADDR_W  port 0 address.
- din0  in  DATA_W  port 0 write data.
- dout0  out  DATA_W  port 0 read data.
- rvalid0  out  1  dout0 carries new read data this cycle.
- read_en1  in  1  port 1 read request.
- write_en1  in  1  port 1 write request.
- addr1  in  ADDR_W  port 1 address.
- din1  in  DATA_W  port 1 write data.
- dout1  out  DATA_W  port 1 read data.
- rvalid1  out  1  dout1 carries new read data this cycle.
- init_done  out  1  high when the RAM accepts accesses.
- collision  out  1  one-cycle pulse: both ports wrote the same address.
- op_err  out  2  one-cycle pulse per port (bit n = port n): read_en and write_en were both asserted.

Behaviour:
- Reset (asynchronous, any time, including mid-clear or mid-read):
  - dout0 = dout1 = 0; rvalid0, rvalid1, collision and op_err = 0.
  - Pipeline registers are cleared.
  - FSM goes to CLEAR if CLEAR_ON_RESET = 1, otherwise READY.
  - The clear counter returns to 0.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[cnt] and increments cnt. When cnt = 2**ADDR_W-1 is written, the next state is READY. Clear therefore takes exactly 2**ADDR_W cycles after reset deasserts.
  - READY: terminal state until the next reset.
  - init_done is a registered output; it is 1 only in READY.
- Accesses while init_done = 0 are dropped: no write, no rvalid, no op_err, no collision.
- Per-port decode (READY only):
  - write_en=1, read_en=0: write. mem[addr] <= din at the edge.
  - write_en=0, read_en=1: read.
  - Both 1: no operation, and the port's op_err bit pulses the following cycle.
  - Both 0: idle. dout holds its last value.
- Read latency:
  - OUT_REG = 0: data appears on dout, with rvalid = 1, on the cycle after the request edge.
  - OUT_REG = 1: one additional cycle.
  - rvalid is a single-cycle pulse per read. Back-to-back reads give back-to-back pulses, full throughput.
- Same-address reads on both ports: both return the same word.
- Read on port A and write on port B to the same address in the same cycle: the read returns the new din (write-first bypass).
- Both ports write the same address in the same cycle:
  - Port 0 wins.
  - collision pulses 1 the following cycle.
  - Any read bypass returns din0.
- Writes to different addresses in the same cycle both complete.
- Address arithmetic is unsigned, no wrap logic needed; the full ADDR_W range is valid.

Decomposition:
- Shared header ram_defs.vh holds:
  - FSM state encodings: ST_CLEAR = 1'b0, ST_READY = 1'b1.
  - Port-op encodings: OP_IDLE, OP_RD, OP_WR, OP_ERR.
- One natural sub-module: ram_clear_seq. It contains the counter, FSM and init_done, and outputs clear_we and clear_addr.
- The top-level module holds the memory array, port decode, bypass/collision logic and output pipeline.

Test Plan:
1. Reset then clear (defaults): assert rst for 3 cycles, deassert -> init_done stays 0 for 128 cycles then goes 1; a read of addr 0x45 then returns 0x0000 with rvalid0 = 1 one cycle later.
2. Basic write/read: port0 writes 0xBEEF to 0x10; next cycle port1 reads 0x10 -> dout1 = 0xBEEF, rvalid1 = 1 one cycle after the read (two cycles with OUT_REG = 1).
3. Collision: both ports write 0x20, din0 = 0x1111 and din1 = 0x2222 -> collision pulses 1 cycle; a subsequent read of 0x20 returns 0x1111.
4. Bypass: port0 writes 0xA5A5 to 0x30 while port1 reads 0x30 in the same cycle -> dout1 = 0xA5A5.
5. Illegal op: port1 asserts read_en1 and write_en1 at 0x05 with din1 = 0xFFFF -> op_err = 2'b10 for 1 cycle, rvalid1 stays 0, and mem[0x05] is unchanged.
6. Reset mid-clear: assert rst at clear cycle 60 -> outputs return to 0 immediately; after release, clear restarts and init_done asserts exactly 128 cycles later. Accesses issued during clear have no effect.

Source files
------------

// File: rtl/ram_2p_param_pkg.sv
// Shared encodings for the dual-port RAM: clear-sequencer states and per-port op decode.
package ram_2p_param_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  // Op code is {write_en, read_en}, so the raw enables cast directly onto it.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_ERR  = 2'b11
  } port_op_e;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: sweeps every address writing zero, then holds READY.
module ram_clear_seq
  import ram_2p_param_pkg::*;
#(
  parameter int ADDR_W         = 7,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              init_done
);

  clr_state_e        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt       <= '0;
      init_done <= (CLEAR_ON_RESET == 0);
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      init_done <= (state_nxt == ST_READY);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_CLEAR: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == '1) state_nxt = ST_READY;
      end
      default: ;
    endcase
  end

  assign clear_we   = (state == ST_CLEAR);
  assign clear_addr = cnt;

endmodule

// File: rtl/ram_2p_param.sv
// Parametrised true dual-port RAM with clear-on-reset, cross-port write-first
// bypass, port-0-wins collision handling and an optional output register.
module ram_2p_param
  import ram_2p_param_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 7,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_en0,
  input  logic              write_en0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] din0,
  output logic [DATA_W-1:0] dout0,
  output logic              rvalid0,
  input  logic              read_en1,
  input  logic              write_en1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] din1,
  output logic [DATA_W-1:0] dout1,
  output logic              rvalid1,
  output logic              init_done,
  output logic              collision,
  output logic [1:0]        op_err
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int STAGES = (OUT_REG != 0) ? 1 : 0;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clear_we;
  logic [ADDR_W-1:0] clear_addr;

  ram_clear_seq #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .init_done  (init_done)
  );

  logic [1:0]             re, we, rd, wr, err;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] din, rdata;
  port_op_e               op [2];

  assign re   = {read_en1, read_en0};
  assign we   = {write_en1, write_en0};
  assign addr = {addr1, addr0};
  assign din  = {din1, din0};

  // Everything is dropped until the clear sweep has finished.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      op[p]  = init_done ? port_op_e'({we[p], re[p]}) : OP_IDLE;
      rd[p]  = (op[p] == OP_RD);
      wr[p]  = (op[p] == OP_WR);
      err[p] = (op[p] == OP_ERR);
    end
  end

  // A port cannot read and write in one cycle, so only the other port can bypass.
  assign rdata[0] = (wr[1] && addr[1] == addr[0]) ? din[1] : mem[addr[0]];
  assign rdata[1] = (wr[0] && addr[0] == addr[1]) ? din[0] : mem[addr[1]];

  // Port 0 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (clear_we) mem[clear_addr] <= '0;
    if (wr[1])    mem[addr[1]]    <= din[1];
    if (wr[0])    mem[addr[0]]    <= din[0];
  end

  logic [STAGES:0][1:0]             vld_pipe;
  logic [STAGES:0][1:0][DATA_W-1:0] dat_pipe;

  // Data registers only load on a valid read, so dout holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      dat_pipe  <= '0;
      collision <= 1'b0;
      op_err    <= '0;
    end else begin
      vld_pipe[0] <= rd;
      for (int p = 0; p < 2; p++)
        if (rd[p]) dat_pipe[0][p] <= rdata[p];
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        for (int p = 0; p < 2; p++)
          if (vld_pipe[s-1][p]) dat_pipe[s][p] <= dat_pipe[s-1][p];
      end
      collision <= wr[0] & wr[1] & (addr[0] == addr[1]);
      op_err    <= err;
    end
  end

  assign dout0   = dat_pipe[STAGES][0];
  assign dout1   = dat_pipe[STAGES][1];
  assign rvalid0 = vld_pipe[STAGES][0];
  assign rvalid1 = vld_pipe[STAGES][1];

endmodule

// File: tb/tb_ram_2p_param.sv
// Randomised bench for ram_2p_param against an array-based reference model of the RAM.
module tb_ram_2p_param;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 7;
  localparam int OUT_REG = 0;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int LAT     = 1 + OUT_REG;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              read_en0 = 0, write_en0 = 0, read_en1 = 0, write_en1 = 0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] din0 = '0, din1 = '0;
  logic [DATA_W-1:0] dout0, dout1;
  logic              rvalid0, rvalid1, init_done, collision;
  logic [1:0]        op_err;

  ram_2p_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_REG(OUT_REG), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst),
    .read_en0(read_en0), .write_en0(write_en0), .addr0(addr0), .din0(din0),
    .dout0(dout0), .rvalid0(rvalid0),
    .read_en1(read_en1), .write_en1(write_en1), .addr1(addr1), .din1(din1),
    .dout1(dout1), .rvalid1(rvalid1),
    .init_done(init_done), .collision(collision), .op_err(op_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                edges;
  logic [1:0]        pv [LAT];
  logic [DATA_W-1:0] pd [LAT][2];
  logic [DATA_W-1:0] exp_dout [2];
  logic [1:0]        exp_rv, exp_err;
  logic              exp_coll, exp_init;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("dout0", 32'(dout0), 32'(exp_dout[0]));
    chk("dout1", 32'(dout1), 32'(exp_dout[1]));
    chk("rvalid0", 32'(rvalid0), 32'(exp_rv[0]));
    chk("rvalid1", 32'(rvalid1), 32'(exp_rv[1]));
    chk("collision", 32'(collision), 32'(exp_coll));
    chk("op_err", 32'(op_err), 32'(exp_err));
    chk("init_done", 32'(init_done), 32'(exp_init));
  endtask

  // Asserts reset asynchronously mid low phase, checks outputs clear at once,
  // holds it for n cycles and releases it on a falling edge.
  task automatic do_reset(input int n);
    #2;
    rst = 1'b1;
    read_en0 = 0; write_en0 = 0; read_en1 = 0; write_en1 = 0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = '0; pd[i][0] = '0; pd[i][1] = '0;
    end
    exp_dout[0] = '0; exp_dout[1] = '0;
    exp_rv = '0; exp_err = '0; exp_coll = 1'b0; exp_init = 1'b0;
    edges = 0;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    #1;
    check_outs();
    repeat (n) @(negedge clk);
    check_outs();
    rst = 1'b0;
  endtask

  task automatic step(input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                      input logic [DATA_W-1:0] d0,
                      input logic r1, input logic w1, input logic [ADDR_W-1:0] a1,
                      input logic [DATA_W-1:0] d1);
    logic ready, rd0, rd1, wr0, wr1;
    logic [DATA_W-1:0] v0, v1;
    read_en0 = r0; write_en0 = w0; addr0 = a0; din0 = d0;
    read_en1 = r1; write_en1 = w1; addr1 = a1; din1 = d1;
    ready = (edges >= DEPTH);
    rd0 = ready && r0 && !w0;  wr0 = ready && w0 && !r0;
    rd1 = ready && r1 && !w1;  wr1 = ready && w1 && !r1;
    v0 = (wr1 && a1 == a0) ? d1 : ref_mem[a0];
    v1 = (wr0 && a0 == a1) ? d0 : ref_mem[a1];
    exp_coll = wr0 && wr1 && (a0 == a1);
    exp_err  = {ready && r1 && w1, ready && r0 && w0};
    if (wr1) ref_mem[a1] = d1;
    if (wr0) ref_mem[a0] = d0;
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1]; pd[i][0] = pd[i-1][0]; pd[i][1] = pd[i-1][1];
    end
    pv[0] = {rd1, rd0}; pd[0][0] = v0; pd[0][1] = v1;
    exp_rv = pv[LAT-1];
    for (int p = 0; p < 2; p++)
      if (exp_rv[p]) exp_dout[p] = pd[LAT-1][p];
    edges++;
    exp_init = (edges >= DEPTH);
    @(posedge clk);
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic rnd_step();
    logic [1:0] o0, o1;
    logic [ADDR_W-1:0] a0, a1;
    o0 = 2'($urandom_range(0, 3));
    o1 = 2'($urandom_range(0, 3));
    // Narrow address window half the time to provoke bypass and collisions.
    if ($urandom_range(0, 1) == 0) begin
      a0 = ADDR_W'($urandom_range(0, 3));
      a1 = ADDR_W'($urandom_range(0, 3));
    end else begin
      a0 = ADDR_W'($urandom_range(0, DEPTH - 1));
      a1 = ADDR_W'($urandom_range(0, DEPTH - 1));
    end
    step(o0[0], o0[1], a0, DATA_W'($urandom), o1[0], o1[1], a1, DATA_W'($urandom));
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) pv[i] = '0;
    @(negedge clk);
    do_reset(3);
    // Reset mid-clear at cycle 60; traffic during clear must be ignored.
    repeat (60) rnd_step();
    do_reset(3);
    repeat (DEPTH) rnd_step();
    chk("init_after_clear", 32'(init_done), 32'd1);

    // Read of a cleared word
    step(1, 0, 7'h45, '0, 0, 0, '0, '0);
    repeat (LAT - 1) idle();
    chk("t1_dout0", 32'(dout0), 32'h0);
    chk("t1_rvalid0", 32'(rvalid0), 32'd1);

    // Basic write then cross-port read
    step(0, 1, 7'h10, 16'hBEEF, 0, 0, '0, '0);
    step(0, 0, '0, '0, 1, 0, 7'h10, '0);
    repeat (LAT - 1) idle();
    chk("t2_dout1", 32'(dout1), 32'hBEEF);
    chk("t2_rvalid1", 32'(rvalid1), 32'd1);

    // Collision: port 0 wins
    step(0, 1, 7'h20, 16'h1111, 0, 1, 7'h20, 16'h2222);
    chk("t3_coll", 32'(collision), 32'd1);
    step(1, 0, 7'h20, '0, 0, 0, '0, '0);
    chk("t3_coll_pulse", 32'(collision), 32'd0);
    repeat (LAT - 1) idle();
    chk("t3_dout0", 32'(dout0), 32'h1111);

    // Write-first bypass
    step(0, 1, 7'h30, 16'hA5A5, 1, 0, 7'h30, '0);
    repeat (LAT - 1) idle();
    chk("t4_bypass", 32'(dout1), 32'hA5A5);

    // Illegal op leaves memory untouched
    step(0, 0, '0, '0, 0, 1, 7'h05, 16'h1234);
    step(0, 0, '0, '0, 1, 1, 7'h05, 16'hFFFF);
    chk("t5_op_err", 32'(op_err), 32'h2);
    chk("t5_rvalid1", 32'(rvalid1), 32'd0);
    step(0, 0, '0, '0, 1, 0, 7'h05, '0);
    chk("t5_op_err_pulse", 32'(op_err), 32'h0);
    repeat (LAT - 1) idle();
    chk("t5_mem05", 32'(dout1), 32'h1234);

    repeat (1500) rnd_step();

    // Reset while holding read data; memory must be cleared again afterwards.
    step(0, 1, 7'h11, 16'h5A5A, 0, 0, '0, '0);
    step(1, 0, 7'h11, '0, 0, 0, '0, '0);
    repeat (LAT - 1) idle();
    chk("t6_pre_rst", 32'(dout0), 32'h5A5A);
    do_reset(2);
    chk("t6_rst_dout0", 32'(dout0), 32'h0);
    repeat (DEPTH) rnd_step();
    step(1, 0, 7'h11, '0, 1, 0, 7'h30, '0);
    repeat (LAT - 1) idle();
    chk("t6_cleared0", 32'(dout0), 32'h0);
    chk("t6_cleared1", 32'(dout1), 32'h0);
    repeat (300) rnd_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
